fetch_prefetch_unit: RTL and testbench

- Instruction-fetch front end feeding the single-cycle core's Instr/PC path.
- Fetches sequential words from a variable-latency instruction memory over a req/ack handshake and buffers up to DEPTH instructions with their PCs.
- Hands instructions to the core over a valid/ready interface.
- Accepts a redirect (taken branch / PC reload) that flushes the buffer and restarts fetch at a new address.

---
 rtl/fetch_prefetch_unit_if.sv | 29 ++
 rtl/fetch_prefetch_unit.sv | 127 ++++++++++++
 tb/tb_fetch_prefetch_unit.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_prefetch_unit_if.sv
// Fetch-unit bus bundle: redirect input, instruction-memory req/ack port and
// the valid/ready instruction stream towards the core.
interface fetch_prefetch_unit_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          redirect;
    logic [31:0]   redirect_pc;
    logic          mem_req;
    logic [31:0]   mem_addr;
    logic          mem_ack;
    logic [31:0]   mem_rdata;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_instr;
    logic [31:0]   out_pc;
    logic [CW-1:0] count;

    modport master (
        input  redirect, redirect_pc, mem_ack, mem_rdata, out_ready,
        output mem_req, mem_addr, out_valid, out_instr, out_pc, count
    );

    modport slave (
        output redirect, redirect_pc, mem_ack, mem_rdata, out_ready,
        input  mem_req, mem_addr, out_valid, out_instr, out_pc, count
    );
endinterface

// File: rtl/fetch_prefetch_unit.sv
// Instruction prefetcher: sequential word fetch over req/ack into a small
// circular {pc, instr} FIFO, with redirect flush and in-flight request drop.
module fetch_prefetch_unit #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  reset,
    fetch_prefetch_unit_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

    state_t        state_q;
    logic [31:0]   fetch_pc_q;
    logic [31:0]   mem_addr_q;
    logic          mem_req_q;
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [31:0]   pc_mem    [DEPTH];
    logic [31:0]   instr_mem [DEPTH];

    logic          push;
    logic          pop;
    logic          space;
    logic [CW-1:0] count_d;
    logic [31:0]   next_addr;
    logic [31:0]   redirect_pc_aligned;

    assign redirect_pc_aligned = bus.redirect_pc & ~32'd3;
    assign next_addr           = mem_addr_q + 32'd4;

    always_comb begin
        pop     = (count_q != '0) && bus.out_ready;
        push    = (state_q == WAIT) && bus.mem_ack && !bus.redirect;
        count_d = count_q;
        // Redirect wins over push and pop; a simultaneous pop is simply consumed.
        if (bus.redirect) begin
            count_d = '0;
        end else if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
        space = count_d < CW'(DEPTH);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            mem_addr_q <= RESET_PC;
            mem_req_q  <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            count_q <= count_d;
            if (bus.redirect) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            end

            case (state_q)
                IDLE: begin
                    if (bus.redirect) begin
                        fetch_pc_q <= redirect_pc_aligned;
                    end else if (space) begin
                        mem_addr_q <= fetch_pc_q;
                        mem_req_q  <= 1'b1;
                        state_q    <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.mem_ack && !bus.redirect) begin
                        fetch_pc_q <= next_addr;
                        if (space) begin
                            mem_addr_q <= next_addr;
                        end else begin
                            mem_req_q <= 1'b0;
                            state_q   <= IDLE;
                        end
                    end else if (bus.mem_ack) begin
                        fetch_pc_q <= redirect_pc_aligned;
                        mem_req_q  <= 1'b0;
                        state_q    <= IDLE;
                    end else if (bus.redirect) begin
                        // The in-flight request cannot be aborted; wait out its ack.
                        fetch_pc_q <= redirect_pc_aligned;
                        state_q    <= DROP;
                    end
                end
                DROP: begin
                    if (bus.redirect) fetch_pc_q <= redirect_pc_aligned;
                    if (bus.mem_ack) begin
                        mem_req_q <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: begin
                    mem_req_q <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !reset) begin
            pc_mem[wr_ptr_q]    <= mem_addr_q;
            instr_mem[wr_ptr_q] <= bus.mem_rdata;
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.count     = count_q;
    assign bus.out_valid = (count_q != '0);
    assign bus.out_pc    = bus.out_valid ? pc_mem[rd_ptr_q]    : 32'd0;
    assign bus.out_instr = bus.out_valid ? instr_mem[rd_ptr_q] : 32'd0;
endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Self-checking bench: directed scenarios plus random traffic against a
// queue-based model of the fetched instruction stream.
module tb_fetch_prefetch_unit;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] PAT      = 32'hA5A5_A5A5;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    fetch_prefetch_unit_if #(.DEPTH(DEPTH)) bus ();

    fetch_prefetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    logic [63:0] exp_q[$];
    logic [31:0] exp_addr;
    logic [31:0] stale_addr;
    bit          stale;
    int          wait_cnt, lat, lat_min, lat_max, stall_cnt, n_push;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic [63:0] head;
        head = (exp_q.size() > 0) ? exp_q[0] : 64'd0;
        check_eq("count", 32'(bus.count), 32'(exp_q.size()));
        check_eq("count_le_depth", 32'(bus.count <= DEPTH), 32'd1);
        check_eq("out_valid", 32'(bus.out_valid), 32'(exp_q.size() > 0));
        check_eq("out_pc", bus.out_pc, head[63:32]);
        check_eq("out_instr", bus.out_instr, head[31:0]);
        if (exp_q.size() == DEPTH) check_eq("no_req_when_full", 32'(bus.mem_req), 32'd0);
        if (bus.mem_req || exp_q.size() == DEPTH || bus.redirect) stall_cnt = 0;
        else stall_cnt++;
        check_eq("fetch_stall", 32'(stall_cnt > 2), 32'd0);
    endtask

    task automatic check_reset_state();
        check_eq("rst_mem_req", 32'(bus.mem_req), 32'd0);
        check_eq("rst_count", 32'(bus.count), 32'd0);
        check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("rst_out_pc", bus.out_pc, 32'd0);
        check_eq("rst_out_instr", bus.out_instr, 32'd0);
        check_eq("rst_mem_addr", bus.mem_addr, RESET_PC);
    endtask

    // Called at a negedge: drives one cycle of inputs and advances the model.
    task automatic step(input bit rdy, input bit rdr, input logic [31:0] rpc);
        bit ack;
        bit do_pop;
        check_outputs();
        ack = 1'b0;
        if (bus.mem_req) begin
            if (wait_cnt >= lat) begin
                ack      = 1'b1;
                wait_cnt = 0;
                lat      = $urandom_range(lat_min, lat_max);
            end else begin
                wait_cnt++;
            end
        end
        bus.mem_ack     = ack;
        bus.mem_rdata   = ack ? (bus.mem_addr ^ PAT) : $urandom();
        bus.out_ready   = rdy;
        bus.redirect    = rdr;
        bus.redirect_pc = rpc;

        do_pop = rdy && (exp_q.size() > 0) && !rdr;
        if (do_pop) begin
            $display("pop pc=%h instr=%h", exp_q[0][63:32], exp_q[0][31:0]);
            void'(exp_q.pop_front());
        end
        if (ack) begin
            if (stale) begin
                check_eq("drop_addr", bus.mem_addr, stale_addr);
                stale = 1'b0;
            end else begin
                check_eq("req_addr", bus.mem_addr, exp_addr);
                if (!rdr) begin
                    exp_q.push_back({exp_addr, exp_addr ^ PAT});
                    exp_addr += 32'd4;
                    n_push++;
                end
            end
        end
        if (rdr) begin
            if (bus.mem_req && !ack && !stale) begin
                stale      = 1'b1;
                stale_addr = exp_addr;
            end
            exp_q.delete();
            exp_addr = rpc & ~32'd3;
        end
        @(negedge clk);
    endtask

    task automatic apply_reset();
        reset           = 1'b1;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'd0;
        bus.mem_ack     = 1'b0;
        bus.mem_rdata   = 32'd0;
        bus.out_ready   = 1'b0;
        @(negedge clk);
        exp_q.delete();
        exp_addr  = RESET_PC;
        stale     = 1'b0;
        wait_cnt  = 0;
        stall_cnt = 0;
        n_push    = 0;
        lat       = $urandom_range(lat_min, lat_max);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        bit found;
        int rdy_bias;
        logic [31:0] rpc;

        // Reset values and the first-valid latency with one-cycle memory.
        lat_min = 1; lat_max = 1;
        apply_reset();
        check_reset_state();
        reset = 1'b0;
        n = 0; found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            step(1'b1, 1'b0, 32'd0);
            n++;
            if (bus.out_valid) found = 1'b1;
        end
        check_eq("first_valid_lat", 32'(n), 32'd3);
        repeat (20) step(1'b1, 1'b0, 32'd0);

        // Fill with the core stalled, then drain and resume.
        lat_min = 0; lat_max = 0;
        apply_reset();
        reset = 1'b0;
        repeat (12) step(1'b0, 1'b0, 32'd0);
        check_eq("fill_count", 32'(bus.count), 32'd4);
        check_eq("fill_req", 32'(bus.mem_req), 32'd0);
        check_eq("fill_acks", 32'(n_push), 32'd4);
        step(1'b1, 1'b0, 32'd0);
        check_eq("resume_req", 32'(bus.mem_req), 32'd1);
        check_eq("resume_addr", bus.mem_addr, 32'h10);
        repeat (10) step(1'b1, 1'b0, 32'd0);

        // Redirect during a slow request: drop the in-flight data.
        lat_min = 5; lat_max = 5;
        apply_reset();
        reset = 1'b0;
        step(1'b1, 1'b0, 32'd0);
        step(1'b1, 1'b0, 32'd0);
        step(1'b1, 1'b1, 32'h100);
        for (int i = 0; i < 2; i++) begin
            check_eq("drop_req", 32'(bus.mem_req), 32'd1);
            check_eq("drop_hold", bus.mem_addr, 32'd0);
            step(1'b1, 1'b0, 32'd0);
        end
        for (int i = 0; i < 10 && bus.mem_req; i++) step(1'b1, 1'b0, 32'd0);
        check_eq("drop_done", 32'(bus.mem_req), 32'd0);
        step(1'b1, 1'b0, 32'd0);
        check_eq("redir_req", 32'(bus.mem_req), 32'd1);
        check_eq("redir_addr", bus.mem_addr, 32'h100);
        repeat (10) step(1'b1, 1'b0, 32'd0);

        // Redirect coinciding with ack and pop, unaligned target, then address wrap.
        lat_min = 0; lat_max = 0;
        apply_reset();
        reset = 1'b0;
        for (int i = 0; i < 10 && bus.count != 2; i++) step(1'b0, 1'b0, 32'd0);
        check_eq("pre_rdr_count", 32'(bus.count), 32'd2);
        step(1'b1, 1'b1, 32'h203);
        check_eq("rdr_count", 32'(bus.count), 32'd0);
        check_eq("rdr_req_low", 32'(bus.mem_req), 32'd0);
        step(1'b1, 1'b0, 32'd0);
        check_eq("rdr_req_high", 32'(bus.mem_req), 32'd1);
        check_eq("rdr_aligned", bus.mem_addr, 32'h200);
        step(1'b1, 1'b1, 32'hFFFF_FFFC);
        repeat (12) step(1'b1, 1'b0, 32'd0);

        // Reset while waiting with three entries buffered.
        apply_reset();
        reset = 1'b0;
        for (int i = 0; i < 10 && bus.count != 3; i++) step(1'b0, 1'b0, 32'd0);
        check_eq("pre_rst_count", 32'(bus.count), 32'd3);
        check_eq("pre_rst_req", 32'(bus.mem_req), 32'd1);
        apply_reset();
        check_reset_state();
        reset = 1'b0;

        // Random traffic: variable latency, bursty ready, occasional redirects.
        lat_min = 0; lat_max = 3;
        apply_reset();
        reset = 1'b0;
        rdy_bias = 4;
        for (int i = 0; i < 4000; i++) begin
            if (i % 200 == 0) rdy_bias = $urandom_range(0, 4);
            rpc = $urandom();
            if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 | (rpc & 32'hF);
            step($urandom_range(0, 3) < rdy_bias, $urandom_range(0, 19) == 0, rpc);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
